// File: rtl/sirv_jtag_arb_pkg.sv
// -----------------------------------------------------------------------------
// sirv_jtag_arb_pkg
// Shared definitions for the JTAG pad arbiter: arbiter state encodings, the
// bit position of each JTAG pad in the 5-bit pad vectors, and the default
// values of the arbiter's timing parameters.
// -----------------------------------------------------------------------------
package sirv_jtag_arb_pkg;

  // Arbiter states. The numeric values are visible on arb_state.
  typedef enum logic [1:0] {
    ARB_JTAG_OWN = 2'd0,
    ARB_DRAIN    = 2'd1,
    ARB_GPIO_OWN = 2'd2,
    ARB_RETURN   = 2'd3
  } arb_state_e;

  // Pad vector layout.
  localparam int unsigned PAD_W      = 5;
  localparam int unsigned PAD_TCK    = 0;
  localparam int unsigned PAD_TMS    = 1;
  localparam int unsigned PAD_TDI    = 2;
  localparam int unsigned PAD_TDO    = 3;
  localparam int unsigned PAD_TRST_N = 4;

  // Parameter defaults.
  localparam int DEF_TLR_EDGES      = 5;
  localparam int DEF_GUARD_CYCLES   = 4;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/sirv_jtag_arb_sync.sv
// -----------------------------------------------------------------------------
// sirv_jtag_arb_sync
// Two-flop synchronizer for asynchronous pad inputs. Each bit has its own
// reset value so that active-low pins can reset to their inactive level.
//
// Ports:
//   clk_i   in   clock
//   rst_ni  in   asynchronous active-low reset
//   d_i     in   WIDTH raw asynchronous inputs
//   q_o     out  WIDTH synchronized outputs
// -----------------------------------------------------------------------------
module sirv_jtag_arb_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sirv_jtag_pin_arb.sv
// -----------------------------------------------------------------------------
// sirv_jtag_pin_arb
// Arbitrates the five JTAG pads (TCK, TMS, TDI, TDO, TRST_n) between the JTAG
// TAP and software GPIO. Software requests the pads with gpio_req; the grant
// is only given once the TAP is provably parked in Test-Logic-Reset
// (TLR_EDGES consecutive TCK rising edges with TMS=1) or TRST_n is asserted.
// On release the pads sit in a safe input/pull-up state for GUARD_CYCLES
// before JTAG takes them back.
//
// Optional feature (macro SIRV_JTAG_ARB_TIMEOUT_EN): a DRAIN timeout that
// gives up after TIMEOUT_CYCLES clocks, pulses gpio_deny and refuses to drain
// again until gpio_req has been seen low. Without the macro DRAIN waits
// forever and gpio_deny is tied low.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   gpio_req                        software level request for the pads
//   gpio_gnt                        pads owned by GPIO (registered)
//   gpio_deny                       one-cycle pulse on drain timeout
//   pin_tck_i/pin_tms_i/pin_trst_n_i raw pad input values
//   jtag_tdo, jtag_drv_tdo          TAP TDO value and drive enable
//   gpio_oval, gpio_oe              software pad drive (5 bits each)
//   pad_oval/pad_oe/pad_ie/pad_pue  pad controls (5 bits each)
//   jtag_en                         TCK gate to the TAP
//   arb_state                       current state encoding
// -----------------------------------------------------------------------------
module sirv_jtag_pin_arb
  import sirv_jtag_arb_pkg::*;
#(
  parameter int TLR_EDGES      = DEF_TLR_EDGES,
  parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gpio_req,
  output logic             gpio_gnt,
  output logic             gpio_deny,
  input  logic             pin_tck_i,
  input  logic             pin_tms_i,
  input  logic             pin_trst_n_i,
  input  logic             jtag_tdo,
  input  logic             jtag_drv_tdo,
  input  logic [PAD_W-1:0] gpio_oval,
  input  logic [PAD_W-1:0] gpio_oe,
  output logic [PAD_W-1:0] pad_oval,
  output logic [PAD_W-1:0] pad_oe,
  output logic [PAD_W-1:0] pad_ie,
  output logic [PAD_W-1:0] pad_pue,
  output logic             jtag_en,
  output logic [1:0]       arb_state
);

  localparam int EW = (TLR_EDGES < 1) ? 1 : $clog2(TLR_EDGES + 1);
  localparam int GW = (GUARD_CYCLES < 2) ? 1 : $clog2(GUARD_CYCLES + 1);
  localparam logic [EW-1:0] EDGE_MAX   = EW'(TLR_EDGES);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Pad input synchronization: bit 0 TCK, bit 1 TMS, bit 2 TRST_n.
  // TRST_n resets high so reset does not look like an asserted TAP reset.
  // ---------------------------------------------------------------------------
  logic [2:0] sync_bits;
  logic       sync_tck;
  logic       sync_tms;
  logic       sync_trst_n;
  logic       tck_prev_q;
  logic       tck_rise;

  sirv_jtag_arb_sync #(
    .WIDTH   (3),
    .RST_VAL (3'b100)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    ({pin_trst_n_i, pin_tms_i, pin_tck_i}),
    .q_o    (sync_bits)
  );

  assign sync_tck    = sync_bits[0];
  assign sync_tms    = sync_bits[1];
  assign sync_trst_n = sync_bits[2];
  assign tck_rise    = sync_tck & ~tck_prev_q;

  // ---------------------------------------------------------------------------
  // State and counters
  // ---------------------------------------------------------------------------
  arb_state_e    state_q, state_d;
  logic [EW-1:0] edge_cnt_q, edge_cnt_d;
  logic [GW-1:0] guard_cnt_q, guard_cnt_d;
  logic          gnt_q, gnt_d;

`ifdef SIRV_JTAG_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          deny_q, deny_d;
  // Set by a timeout; cleared once gpio_req is observed low.
  logic          lock_q, lock_d;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_JTAG_OWN;
      edge_cnt_q  <= '0;
      guard_cnt_q <= '0;
      gnt_q       <= 1'b0;
      tck_prev_q  <= 1'b0;
`ifdef SIRV_JTAG_ARB_TIMEOUT_EN
      to_cnt_q    <= '0;
      deny_q      <= 1'b0;
      lock_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      edge_cnt_q  <= edge_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      gnt_q       <= gnt_d;
      tck_prev_q  <= sync_tck;
`ifdef SIRV_JTAG_ARB_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      deny_q      <= deny_d;
      lock_q      <= lock_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    edge_cnt_d  = edge_cnt_q;
    guard_cnt_d = guard_cnt_q;
`ifdef SIRV_JTAG_ARB_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    deny_d      = 1'b0;
    lock_d      = lock_q & gpio_req;
`endif

    unique case (state_q)
      ARB_JTAG_OWN: begin
`ifdef SIRV_JTAG_ARB_TIMEOUT_EN
        if (gpio_req && !lock_q) begin
          to_cnt_d = '0;
`else
        if (gpio_req) begin
`endif
          state_d    = ARB_DRAIN;
          edge_cnt_d = '0;
        end
      end

      ARB_DRAIN: begin
        // TMS=1 edges build toward Test-Logic-Reset; a TMS=0 edge means the
        // TAP may have left it, so the proof starts over.
        if (tck_rise) begin
          if (!sync_tms) begin
            edge_cnt_d = '0;
          end else if (edge_cnt_q != EDGE_MAX) begin
            edge_cnt_d = edge_cnt_q + EW'(1);
          end
        end

        // Withdrawal of the request wins over everything else.
        if (!gpio_req) begin
          state_d = ARB_JTAG_OWN;
        end else if ((edge_cnt_q == EDGE_MAX) || !sync_trst_n) begin
          state_d = ARB_GPIO_OWN;
`ifdef SIRV_JTAG_ARB_TIMEOUT_EN
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ARB_JTAG_OWN;
          deny_d  = 1'b1;
          lock_d  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
`endif
        end
      end

      ARB_GPIO_OWN: begin
        if (!gpio_req) begin
          state_d     = ARB_RETURN;
          guard_cnt_d = '0;
        end
      end

      ARB_RETURN: begin
        // gpio_req deliberately not consulted here.
        if (guard_cnt_q == GUARD_LAST) begin
          state_d = ARB_JTAG_OWN;
        end else begin
          guard_cnt_d = guard_cnt_q + GW'(1);
        end
      end

      default: state_d = ARB_JTAG_OWN;
    endcase

    // Grant is registered and tracks the state being entered, so it rises
    // with GPIO_OWN and falls with RETURN.
    gnt_d = (state_d == ARB_GPIO_OWN);
  end

  // Output logic: pads follow the state register combinationally.
  always_comb begin
    pad_oval  = '0;
    pad_oe    = '0;
    pad_ie    = '1;
    pad_pue   = '1;
    jtag_en   = 1'b0;
    arb_state = state_q;

    unique case (state_q)
      ARB_JTAG_OWN, ARB_DRAIN: begin
        jtag_en = 1'b1;
        pad_oval[PAD_TCK]    = 1'b0;
        pad_oval[PAD_TMS]    = 1'b0;
        pad_oval[PAD_TDI]    = 1'b0;
        pad_oval[PAD_TRST_N] = 1'b0;
        pad_oval[PAD_TDO]    = jtag_tdo;
        pad_oe[PAD_TDO]      = jtag_drv_tdo;
        pad_ie[PAD_TDO]      = 1'b0;
        pad_pue[PAD_TDO]     = 1'b0;
      end
      ARB_GPIO_OWN: begin
        pad_oval = gpio_oval;
        pad_oe   = gpio_oe;
        pad_ie   = '1;
        pad_pue  = '0;
      end
      default: begin
        // RETURN: everything a pulled-up input until JTAG takes over.
      end
    endcase
  end

  assign gpio_gnt = gnt_q;

`ifdef SIRV_JTAG_ARB_TIMEOUT_EN
  assign gpio_deny = deny_q;
`else
  assign gpio_deny = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_sirv_jtag_pin_arb.sv
// -----------------------------------------------------------------------------
// tb_sirv_jtag_pin_arb
// Directed bench for sirv_jtag_pin_arb with default parameters
// (TLR_EDGES=5, GUARD_CYCLES=4, TIMEOUT_CYCLES=4096). The timeout scenario is
// compiled in when SIRV_JTAG_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_sirv_jtag_pin_arb;
  import sirv_jtag_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       gpio_req;
  logic       gpio_gnt;
  logic       gpio_deny;
  logic       pin_tck_i;
  logic       pin_tms_i;
  logic       pin_trst_n_i;
  logic       jtag_tdo;
  logic       jtag_drv_tdo;
  logic [4:0] gpio_oval;
  logic [4:0] gpio_oe;
  logic [4:0] pad_oval;
  logic [4:0] pad_oe;
  logic [4:0] pad_ie;
  logic [4:0] pad_pue;
  logic       jtag_en;
  logic [1:0] arb_state;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_q[$];

  sirv_jtag_pin_arb dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gpio_req     (gpio_req),
    .gpio_gnt     (gpio_gnt),
    .gpio_deny    (gpio_deny),
    .pin_tck_i    (pin_tck_i),
    .pin_tms_i    (pin_tms_i),
    .pin_trst_n_i (pin_trst_n_i),
    .jtag_tdo     (jtag_tdo),
    .jtag_drv_tdo (jtag_drv_tdo),
    .gpio_oval    (gpio_oval),
    .gpio_oe      (gpio_oe),
    .pad_oval     (pad_oval),
    .pad_oe       (pad_oe),
    .pad_ie       (pad_ie),
    .pad_pue      (pad_pue),
    .jtag_en      (jtag_en),
    .arb_state    (arb_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One TCK pulse, long enough to cross the synchronizer.
  task automatic tck_edge(input logic tms);
    pin_tms_i = tms;
    pin_tck_i = 1'b1;
    repeat (3) tick();
    pin_tck_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] tms_pat;
    logic [1:0] exp_st;
    int         got;
    int         n;
    int         cnt;

    rst_n        = 1'b0;
    gpio_req     = 1'b0;
    pin_tck_i    = 1'b0;
    pin_tms_i    = 1'b0;
    pin_trst_n_i = 1'b1;
    jtag_tdo     = 1'b0;
    jtag_drv_tdo = 1'b0;
    gpio_oval    = 5'h00;
    gpio_oe      = 5'h00;

    // Reset values
    repeat (3) tick();
    chk("rst_state",   32'(arb_state), 32'd0);
    chk("rst_gnt",     32'(gpio_gnt),  32'd0);
    chk("rst_deny",    32'(gpio_deny), 32'd0);
    chk("rst_jtag_en", 32'(jtag_en),   32'd1);
    chk("rst_pad_oe",  32'(pad_oe),    32'h00);
    chk("rst_pad_ie",  32'(pad_ie),    32'h17);
    chk("rst_pad_pue", 32'(pad_pue),   32'h17);
    rst_n = 1'b1;
    tick();

    // TLR sequence without a request changes nothing
    repeat (5) tck_edge(1'b1);
    chk("idle_state",   32'(arb_state), 32'd0);
    chk("idle_pad_oe",  32'(pad_oe),    32'h00);
    chk("idle_jtag_en", 32'(jtag_en),   32'd1);
    chk("idle_gnt",     32'(gpio_gnt),  32'd0);

    // TDO pass-through
    jtag_tdo = 1'b1;
    jtag_drv_tdo = 1'b1;
    #1;
    chk("tdo_oval", 32'(pad_oval), 32'h08);
    chk("tdo_oe",   32'(pad_oe),   32'h08);
    jtag_tdo = 1'b0;
    jtag_drv_tdo = 1'b0;

    // Request + 5 TLR edges -> GPIO_OWN
    gpio_oval = 5'h15;
    gpio_oe   = 5'h1F;
    gpio_req  = 1'b1;
    tick();
    chk("drain_state",   32'(arb_state), 32'd1);
    chk("drain_jtag_en", 32'(jtag_en),   32'd1);
    repeat (5) tck_edge(1'b1);
    chk("gpio_state",   32'(arb_state), 32'd2);
    chk("gpio_gnt",     32'(gpio_gnt),  32'd1);
    chk("gpio_oval",    32'(pad_oval),  32'h15);
    chk("gpio_oe",      32'(pad_oe),    32'h1F);
    chk("gpio_ie",      32'(pad_ie),    32'h1F);
    chk("gpio_pue",     32'(pad_pue),   32'h00);
    chk("gpio_jtag_en", 32'(jtag_en),   32'd0);
    gpio_oval = 5'h0A;
    gpio_oe   = 5'h05;
    #1;
    chk("gpio_oval2", 32'(pad_oval), 32'h0A);
    chk("gpio_oe2",   32'(pad_oe),   32'h05);

    // Release: RETURN for 4 cycles (request re-raised mid-RETURN is ignored),
    // then JTAG_OWN, then DRAIN again.
    gpio_req = 1'b0;
    exp_q = {2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_st = exp_q.pop_front();
      chk("ret_state", 32'(arb_state), 32'(exp_st));
      if (i < 4) begin
        chk("ret_pad_oe",  32'(pad_oe),  32'h00);
        chk("ret_pad_pue", 32'(pad_pue), 32'h1F);
      end
      if (i == 0) chk("ret_gnt_fall", 32'(gpio_gnt), 32'd0);
      if (i == 1) gpio_req = 1'b1;
    end

    // TMS pattern 1,1,0,1,1,1,1,1: grant only after the 8th edge
    tms_pat = 8'b1111_1011;
    for (int i = 0; i < 7; i++) begin
      tck_edge(tms_pat[i]);
      chk("pat_hold_state", 32'(arb_state), 32'd1);
    end
    chk("pat_hold_gnt", 32'(gpio_gnt), 32'd0);
    tck_edge(tms_pat[7]);
    chk("pat_gnt_state", 32'(arb_state), 32'd2);
    chk("pat_gnt",       32'(gpio_gnt),  32'd1);

    gpio_req = 1'b0;
    repeat (5) tick();
    chk("pat_back_state", 32'(arb_state), 32'd0);

    // TRST_n low with TCK idle
    gpio_req = 1'b1;
    tick();
    chk("trst_drain", 32'(arb_state), 32'd1);
    pin_trst_n_i = 1'b0;
    got = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (gpio_gnt) begin
        got = 1;
        break;
      end
    end
    chk("trst_gnt",   32'(got),       32'd1);
    chk("trst_state", 32'(arb_state), 32'd2);
    pin_trst_n_i = 1'b1;

    // Asynchronous reset while GPIO owns the pads
    jtag_drv_tdo = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_state",   32'(arb_state), 32'd0);
    chk("mrst_gnt",     32'(gpio_gnt),  32'd0);
    chk("mrst_pad_oe",  32'(pad_oe),    32'h08);
    chk("mrst_pad_ie",  32'(pad_ie),    32'h17);
    chk("mrst_jtag_en", 32'(jtag_en),   32'd1);
    gpio_req = 1'b0;
    jtag_drv_tdo = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_after", 32'(arb_state), 32'd0);

    // Abort from DRAIN; the edge count must restart on the next DRAIN
    gpio_req = 1'b1;
    tick();
    tck_edge(1'b1);
    tck_edge(1'b1);
    gpio_req = 1'b0;
    tick();
    chk("abort_state", 32'(arb_state), 32'd0);
    chk("abort_gnt",   32'(gpio_gnt),  32'd0);
    chk("abort_deny",  32'(gpio_deny), 32'd0);
    gpio_req = 1'b1;
    tick();
    repeat (4) tck_edge(1'b1);
    chk("abort_cnt_clear", 32'(arb_state), 32'd1);
    tck_edge(1'b1);
    chk("abort_regrant", 32'(arb_state), 32'd2);
    gpio_req = 1'b0;
    repeat (5) tick();
    chk("abort_back", 32'(arb_state), 32'd0);

`ifdef SIRV_JTAG_ARB_TIMEOUT_EN
    // Drain timeout with TCK idle
    gpio_req = 1'b1;
    tick();
    n = 0;
    cnt = 0;
    while (arb_state == 2'd1 && n < 5000) begin
      n++;
      if (gpio_deny) cnt++;
      tick();
    end
    chk("to_cycles",      32'(n),         32'd4096);
    chk("to_deny_early",  32'(cnt),       32'd0);
    chk("to_state",       32'(arb_state), 32'd0);
    chk("to_deny",        32'(gpio_deny), 32'd1);
    tick();
    chk("to_deny_fall",   32'(gpio_deny), 32'd0);
    cnt = 0;
    repeat (20) begin
      tick();
      if (arb_state != 2'd0 || gpio_deny) cnt++;
    end
    chk("to_locked", 32'(cnt), 32'd0);
    gpio_req = 1'b0;
    tick();
    gpio_req = 1'b1;
    tick();
    chk("to_unlock", 32'(arb_state), 32'd1);
    gpio_req = 1'b0;
    repeat (2) tick();
`else
    // Without the timeout DRAIN holds indefinitely
    gpio_req = 1'b1;
    tick();
    repeat (100) tick();
    chk("no_to_state", 32'(arb_state), 32'd1);
    chk("no_to_deny",  32'(gpio_deny), 32'd0);
    gpio_req = 1'b0;
    tick();
    chk("no_to_back", 32'(arb_state), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sirv_jtag_pin_arb.md
SIRV_JTAG_PIN_ARB -- requirements
Module: sirv_jtag_pin_arb

Interface
REQ-001 SHALL have parameters: TLR_EDGES, default 5, TCK rising edges with TMS=1 that prove the TAP is in Test-Logic-Reset; GUARD_CYCLES, default 4, clk cycles pads stay safe before JTAG regains them; TIMEOUT_CYCLES, default 4096, drain limit.
REQ-002 SHALL have ports:
- clk  in  1  block clock.
- rst_n  in  1  reset, asynchronous, active-low.
- gpio_req  in  1  software level request for the 5 JTAG pads.
- gpio_gnt  out  1  pads owned by GPIO.
- gpio_deny  out  1  one-cycle pulse when a drain times out.
- pin_tck_i, pin_tms_i, pin_trst_n_i  in  1 each  raw pad input values.
- jtag_tdo, jtag_drv_tdo  in  1 each  TAP TDO value and TDO drive enable.
- gpio_oval, gpio_oe  in  5 each  software pad drive.
- pad_oval, pad_oe, pad_ie, pad_pue  out  5 each  pad controls.
- jtag_en  out  1  TCK gate to the TAP.
- arb_state  out  2  current state encoding.
REQ-003 SHALL use pad bit order 0=TCK, 1=TMS, 2=TDI, 3=TDO, 4=TRST_n.

Function
REQ-004 SHALL implement FSM states JTAG_OWN=0, DRAIN=1, GPIO_OWN=2, RETURN=3, with arb_state equal to the encoding.
REQ-005 SHALL synchronize pin_tck_i, pin_tms_i and pin_trst_n_i through 2 flops each; a TCK rising edge is sync_tck=1 with previous sync_tck=0.
REQ-006 JTAG_OWN: gpio_req=1 SHALL go to DRAIN next cycle and clear the edge counter and timeout counter.
REQ-007 DRAIN: each TCK rising edge with sync_tms=1 SHALL increment the edge counter, saturating at TLR_EDGES; an edge with sync_tms=0 SHALL clear it.
REQ-008 DRAIN SHALL go to GPIO_OWN when the edge counter equals TLR_EDGES or sync_trst_n=0.
REQ-009 DRAIN with gpio_req=0 SHALL return to JTAG_OWN next cycle, with no grant and no deny; this takes priority over REQ-008.
REQ-010 GPIO_OWN: gpio_gnt SHALL be a registered 1; gpio_req=0 SHALL go to RETURN, and gpio_gnt SHALL fall in the same cycle RETURN is entered.
REQ-011 RETURN SHALL last exactly GUARD_CYCLES cycles, then go to JTAG_OWN; gpio_req is ignored throughout RETURN.
REQ-012 jtag_en SHALL be 1 in JTAG_OWN and DRAIN, and 0 otherwise.
REQ-013 Pad outputs in JTAG_OWN and DRAIN:
- TCK, TMS, TDI, TRST_n: oval=0, oe=0, ie=1, pue=1.
- TDO: oval=jtag_tdo, oe=jtag_drv_tdo, ie=0, pue=0.
REQ-014 Pad outputs in GPIO_OWN: all bits oval=gpio_oval, oe=gpio_oe, ie=1, pue=0.
REQ-015 Pad outputs in RETURN: all bits oval=0, oe=0, ie=1, pue=1.
REQ-016 Pad outputs SHALL be combinational from the state register and inputs, with no added latency.

Reset
REQ-017 While rst_n=0: state=JTAG_OWN, gpio_gnt=0, gpio_deny=0, all counters 0, TCK/TMS sync flops 0, TRST_n sync flops 1.
REQ-018 Asserting rst_n mid-operation (including in GPIO_OWN) SHALL immediately return the pads to the REQ-013 values.

Configuration
REQ-019 With SIRV_JTAG_ARB_TIMEOUT_EN defined, DRAIN SHALL count clk cycles; reaching TIMEOUT_CYCLES without quiescence SHALL return to JTAG_OWN and pulse gpio_deny for 1 cycle.
REQ-020 After a deny, the block SHALL NOT re-enter DRAIN until gpio_req has been seen low.
REQ-021 Without SIRV_JTAG_ARB_TIMEOUT_EN: no timeout counter, DRAIN waits indefinitely, gpio_deny tied 0.

Structure
REQ-022 State encodings, pad bit indices and parameter defaults SHALL live in package sirv_jtag_arb_pkg.
REQ-023 The synchronizer SHALL be sub-module sirv_jtag_arb_sync (2-flop, per-bit reset value); everything else stays in one module.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Reset, then 5 TCK edges with TMS=1 and gpio_req=0: state stays 0, pad_oe=5'b00000 with jtag_drv_tdo=0, jtag_en=1.
- gpio_req=1, then 5 TCK edges with TMS=1: GPIO_OWN reached; gpio_gnt=1; pad_oval/pad_oe follow gpio_oval=5'h15, gpio_oe=5'h1F; jtag_en=0.
- In DRAIN, TMS pattern 1,1,0,1,1,1,1,1: grant only after the 5th consecutive 1.
- In DRAIN, pin_trst_n_i=0 with TCK idle: gnt=1 within 4 cycles.
- Release gpio_req: gnt falls next cycle, state=3 for exactly 4 cycles with pad_oe=0, then state=0.
- With SIRV_JTAG_ARB_TIMEOUT_EN and TCK idle: gpio_deny pulses once at cycle 4096 of DRAIN, and no new DRAIN occurs until gpio_req toggles.
